// File: rtl/hdmi_pkg.sv
// Shared types and pixel-word layout for the frame-buffer reader.
// FIFO entries carry the RGB pixel plus its line/frame markers.
package hdmi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_DRAIN = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  localparam int PIX_W     = 24;
  localparam int HLAST_BIT = 24;
  localparam int VLAST_BIT = 25;
  localparam int ENTRY_W   = 26;

  function automatic logic [ENTRY_W-1:0] pix_entry(
    input logic             vlast,
    input logic             hlast,
    input logic [PIX_W-1:0] rgb
  );
    return {vlast, hlast, rgb};
  endfunction

endpackage

// File: rtl/hdmi_frame_reader_sfifo.sv
// Synchronous FIFO, registered write, first-word-fall-through read.
// Flush empties it in one cycle and wins over a same-cycle write.
module sfifo #(
  parameter int W      = 26,
  parameter int LGFIFO = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic [W-1:0]      i_data,
  input  logic              i_rd,
  output logic [W-1:0]      o_data,
  output logic              o_empty,
  output logic [LGFIFO:0]   o_fill
);

  localparam int DEPTH = 1 << LGFIFO;

  logic [W-1:0]        mem [DEPTH];
  logic [LGFIFO-1:0]   wr_ptr;
  logic [LGFIFO-1:0]   rd_ptr;
  logic                full;
  logic                do_wr;
  logic                do_rd;

  assign full    = o_fill[LGFIFO];
  assign o_empty = (o_fill == '0);
  assign do_rd   = i_rd && !o_empty;
  assign do_wr   = i_wr && (!full || do_rd);
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_wr && !i_flush)
      mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_fill <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_fill <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      o_fill <= o_fill
              + (LGFIFO+1)'(do_wr)
              - (LGFIFO+1)'(do_rd);
    end
  end

endmodule

// File: rtl/hdmi_frame_reader.sv
// Wishbone frame-buffer reader: fetches lines of 32-bit pixels and
// streams them out with hlast/vlast markers through a credit-gated FIFO.
import hdmi_pkg::*;

module hdmi_frame_reader #(
  parameter int AW     = 30,
  parameter int LW     = 12,
  parameter int LGFIFO = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [AW-1:0]     i_base_addr,
  input  logic [LW-1:0]     i_words_per_line,
  input  logic [LW-1:0]     i_npix,
  input  logic [LW-1:0]     i_nlines,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic              i_wb_err,
  input  logic [31:0]       i_wb_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic              o_pix_hlast,
  output logic              o_pix_vlast,
  output logic              o_err
);

  localparam logic [LGFIFO+1:0] DEPTH =
    (LGFIFO+2)'(1) << LGFIFO;

  state_t              state;
  logic [AW-1:0]       line_addr;
  logic [AW-1:0]       next_line;
  logic [LW-1:0]       stride;
  logic [LW-1:0]       npix;
  logic [LW-1:0]       nlines;
  logic [LW-1:0]       reqs_left;
  logic [LW-1:0]       ack_cnt;
  logic [LW-1:0]       line_cnt;
  logic [LGFIFO:0]     outstanding;
  logic [LGFIFO:0]     out_next;
  logic [LGFIFO:0]     fill;
  logic [LGFIFO+1:0]   credit;
  logic                need_low;
  logic                cfg_ok;
  logic                accept;
  logic                ack;
  logic                bus_err;
  logic                hlast;
  logic                vlast;
  logic                last_line;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  rd_entry;
  logic                unused_bits;

  assign o_wb_we   = 1'b0;
  assign o_wb_sel  = 4'hf;
  assign o_wb_cyc  = (state == S_BUS) || (state == S_DRAIN);
  assign credit    = {1'b0, fill} + {1'b0, outstanding};
  assign o_wb_stb  = (state == S_BUS) && (reqs_left != '0)
                   && (credit < DEPTH);
  assign accept    = o_wb_stb && !i_wb_stall;
  assign bus_err   = o_wb_cyc && i_wb_err;
  assign ack       = o_wb_cyc && i_wb_ack && !i_wb_err;
  assign out_next  = outstanding
                   + (LGFIFO+1)'(accept)
                   - (LGFIFO+1)'(ack);
  assign cfg_ok    = i_en && (i_npix != '0) && (i_nlines != '0);
  assign last_line = (line_cnt == nlines - LW'(1));
  assign hlast     = (ack_cnt == npix - LW'(1));
  assign vlast     = hlast && last_line;
  assign next_line = line_addr + AW'(stride);
  assign wr_entry  = pix_entry(vlast, hlast, i_wb_data[PIX_W-1:0]);
  assign unused_bits = ^i_wb_data[31:PIX_W];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      line_addr   <= '0;
      o_wb_addr   <= '0;
      stride      <= '0;
      npix        <= '0;
      nlines      <= '0;
      reqs_left   <= '0;
      ack_cnt     <= '0;
      line_cnt    <= '0;
      outstanding <= '0;
      need_low    <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (ack)
        ack_cnt <= ack_cnt + LW'(1);
      if (bus_err) begin
        state       <= S_IDLE;
        outstanding <= '0;
        reqs_left   <= '0;
        o_err       <= 1'b1;
        need_low    <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (!i_en) begin
              need_low <= 1'b0;
            end else if (!need_low && cfg_ok) begin
              stride      <= i_words_per_line;
              npix        <= i_npix;
              nlines      <= i_nlines;
              line_addr   <= i_base_addr;
              o_wb_addr   <= i_base_addr;
              reqs_left   <= i_npix;
              ack_cnt     <= '0;
              line_cnt    <= '0;
              outstanding <= '0;
              state       <= S_BUS;
            end
          end
          S_BUS: begin
            outstanding <= out_next;
            if (accept) begin
              o_wb_addr <= o_wb_addr + AW'(1);
              reqs_left <= reqs_left - LW'(1);
              if (reqs_left == LW'(1))
                state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            outstanding <= out_next;
            if (out_next == '0)
              state <= S_NEXT;
          end
          S_NEXT: begin
            line_addr <= next_line;
            o_wb_addr <= next_line;
            ack_cnt   <= '0;
            if (!last_line) begin
              reqs_left <= npix;
              line_cnt  <= line_cnt + LW'(1);
              state     <= S_BUS;
            end else if (cfg_ok) begin
              // back-to-back frame: relatch and restart from base
              stride    <= i_words_per_line;
              npix      <= i_npix;
              nlines    <= i_nlines;
              line_addr <= i_base_addr;
              o_wb_addr <= i_base_addr;
              reqs_left <= i_npix;
              line_cnt  <= '0;
              state     <= S_BUS;
            end else begin
              state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  sfifo #(
    .W      (ENTRY_W),
    .LGFIFO (LGFIFO)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (bus_err),
    .i_wr    (ack),
    .i_data  (wr_entry),
    .i_rd    (i_pix_ready),
    .o_data  (rd_entry),
    .o_empty (fifo_empty),
    .o_fill  (fill)
  );

  assign o_pix_valid = !fifo_empty;
  assign o_pix_data  = rd_entry[PIX_W-1:0];
  assign o_pix_hlast = o_pix_valid && rd_entry[HLAST_BIT];
  assign o_pix_vlast = o_pix_valid && rd_entry[VLAST_BIT];

endmodule

// File: tb/tb_hdmi_frame_reader.sv
// Bench for hdmi_frame_reader: random Wishbone slave, frame model
// built from base/stride/npix/nlines, per-cycle stream compare.
module tb_hdmi_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [29:0] base;
  logic [11:0] stride;
  logic [11:0] npix;
  logic [11:0] nlines;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic        ack;
  logic        stall;
  logic        err;
  logic [31:0] wdata;
  logic        pv;
  logic        pr;
  logic [23:0] pd;
  logic        ph;
  logic        pvl;
  logic        oerr;

  always #5 clk = ~clk;

  hdmi_frame_reader dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_en             (en),
    .i_base_addr      (base),
    .i_words_per_line (stride),
    .i_npix           (npix),
    .i_nlines         (nlines),
    .o_wb_cyc         (cyc),
    .o_wb_stb         (stb),
    .o_wb_we          (we),
    .o_wb_addr        (addr),
    .o_wb_sel         (sel),
    .i_wb_ack         (ack),
    .i_wb_stall       (stall),
    .i_wb_err         (err),
    .i_wb_data        (wdata),
    .o_pix_valid      (pv),
    .i_pix_ready      (pr),
    .o_pix_data       (pd),
    .o_pix_hlast      (ph),
    .o_pix_vlast      (pvl),
    .o_err            (oerr)
  );

  typedef struct {
    logic [29:0] a;
    int          due;
  } req_t;

  int tests = 0;
  int fails = 0;

  int stall_pct = 0;
  int max_dly = 0;
  int ready_mode = 1;
  int err_at = 0;
  int ack_count = 0;
  int err_seen = 0;
  int vlast_cnt = 0;
  int cyc_n = 0;
  int lowc = 0;
  int en_cyc = 0;
  int acked_m = 0;
  int popped_m = 0;

  req_t        inflight[$];
  logic [29:0] exp_addr[$];
  logic [25:0] exp_pix[$];
  logic [29:0] addr_log[$];
  logic [25:0] pix_log[$];
  int          acc_cyc[$];
  int          acc_low[$];

  bit          p_ack = 0;
  bit          p_pop = 0;
  bit          p_err = 0;
  bit          p_hold = 0;
  logic [26:0] h_val;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got nothing, want an event", name);
  endtask

  function automatic logic [31:0] memf(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic int frame_size();
    return int'(npix) * int'(nlines);
  endfunction

  // Expected fetch order and pixel stream of one whole frame.
  task automatic push_frame();
    logic [29:0] a;
    logic [31:0] d;
    bit          hl;
    bit          vl;
    for (int l = 0; l < int'(nlines); l++) begin
      for (int p = 0; p < int'(npix); p++) begin
        a  = base + 30'(l) * 30'(stride) + 30'(p);
        d  = memf(a);
        hl = (p == int'(npix) - 1);
        vl = hl && (l == int'(nlines) - 1);
        exp_addr.push_back(a);
        exp_pix.push_back({vl, hl, d[23:0]});
      end
    end
  endtask

  // Bus slave, consumer and compare process, all at the falling edge.
  initial begin
    int fill_m;
    ack   = 1'b0;
    err   = 1'b0;
    stall = 1'b0;
    pr    = 1'b0;
    wdata = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rst) begin
        inflight.delete();
        exp_pix.delete();
        exp_addr.delete();
        acked_m  = 0;
        popped_m = 0;
        p_ack    = 0;
        p_pop    = 0;
        p_err    = 0;
        p_hold   = 0;
        ack      = 1'b0;
        err      = 1'b0;
        continue;
      end
      if (p_err) begin
        err_seen++;
        chk("err_pulse", oerr, 1);
        chk("err_cyc_drop", cyc, 0);
        chk("err_flush", pv, 0);
        acked_m  = 0;
        popped_m = 0;
        p_hold   = 0;
        inflight.delete();
        exp_pix.delete();
        exp_addr.delete();
      end else begin
        chk("err_quiet", oerr, 0);
        if (p_ack) acked_m++;
        if (p_pop) popped_m++;
      end
      if (!cyc) begin
        lowc++;
        inflight.delete();
      end
      fill_m = acked_m - popped_m;
      chk("valid_vs_fill", pv, fill_m > 0);
      chk("credit", (fill_m + inflight.size()) <= 32, 1);
      if (stb)
        chk("stb_credit", (fill_m + inflight.size()) < 32, 1);
      if (p_hold)
        chk("hold", {pv, pvl, ph, pd}, h_val);
      if (en && frame_size() > 0 && exp_addr.size() < frame_size())
        push_frame();

      stall = ($urandom_range(99) < stall_pct);
      case (ready_mode)
        0:       pr = ($urandom_range(99) < 70);
        1:       pr = 1'b1;
        default: pr = 1'b0;
      endcase

      p_pop = pv && pr;
      if (p_pop) begin
        pix_log.push_back({pvl, ph, pd});
        if (pvl) vlast_cnt++;
        if (exp_pix.size() == 0)
          fail_now("pix_extra");
        else
          chk("pix", {pvl, ph, pd}, exp_pix.pop_front());
      end

      if (stb && !stall) begin
        addr_log.push_back(addr);
        acc_cyc.push_back(cyc_n);
        acc_low.push_back(lowc);
        if (exp_addr.size() == 0)
          fail_now("addr_extra");
        else
          chk("addr", addr, exp_addr.pop_front());
        inflight.push_back('{a: addr,
          due: cyc_n + 1 + int'($urandom_range(max_dly))});
      end

      ack   = 1'b0;
      err   = 1'b0;
      p_ack = 0;
      p_err = 0;
      if (cyc && inflight.size() > 0 && inflight[0].due <= cyc_n) begin
        ack_count++;
        if (err_at != 0 && ack_count == err_at) begin
          err   = 1'b1;
          p_err = 1;
        end else begin
          ack   = 1'b1;
          wdata = memf(inflight[0].a);
          p_ack = 1;
        end
        void'(inflight.pop_front());
      end

      p_hold = pv && !pr;
      h_val  = {pv, pvl, ph, pd};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_model();
    exp_addr.delete();
    exp_pix.delete();
  endtask

  task automatic wait_idle(input string name);
    int q = 0;
    int n = 0;
    while (q < 20 && n < 5000) begin
      tick();
      n++;
      if (!cyc && !pv) q++;
      else q = 0;
    end
    if (q < 20) fail_now({name, "_idle_timeout"});
  endtask

  task automatic run_frames(input string name, input int nf);
    int n = 0;
    int left;
    vlast_cnt = 0;
    en_cyc = cyc_n;
    en = 1'b1;
    while (vlast_cnt < nf && n < 20000) begin
      tick();
      n++;
    end
    if (vlast_cnt < nf) fail_now({name, "_frame_timeout"});
    en = 1'b0;
    wait_idle(name);
    left = exp_pix.size();
    chk({name, "_leftover"},
        (left == exp_addr.size()) &&
        (left == 0 || left == frame_size()), 1);
    clear_model();
  endtask

  initial begin
    int cyc_hi;
    int n;
    logic [29:0] lit_a [8];
    logic [7:0]  lit_h;
    logic [7:0]  lit_v;
    logic [31:0] d0;
    lit_a = '{30'h100, 30'h101, 30'h102, 30'h103,
              30'h108, 30'h109, 30'h10A, 30'h10B};
    lit_h = 8'b1000_1000;
    lit_v = 8'b1000_0000;

    rst = 1'b1;
    en = 1'b0;
    base = '0;
    stride = '0;
    npix = '0;
    nlines = '0;
    #12;
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_sel", sel, 4'hf);
    chk("rst_valid", pv, 0);
    chk("rst_hlast", ph, 0);
    chk("rst_vlast", pvl, 0);
    chk("rst_err", oerr, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_cyc", cyc, 0);

    // Directed single frame, ideal bus and consumer.
    base = 30'h100;
    npix = 12'd4;
    nlines = 12'd2;
    stride = 12'd8;
    stall_pct = 0;
    max_dly = 0;
    ready_mode = 1;
    addr_log.delete();
    pix_log.delete();
    acc_cyc.delete();
    acc_low.delete();
    run_frames("dir", 1);
    if (addr_log.size() < 8 || pix_log.size() < 8) begin
      fail_now("dir_count");
    end else begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("dir_addr%0d", i), addr_log[i], lit_a[i]);
        chk($sformatf("dir_hlast%0d", i), pix_log[i][24], lit_h[i]);
        chk($sformatf("dir_vlast%0d", i), pix_log[i][25], lit_v[i]);
      end
      d0 = memf(30'h100);
      chk("dir_pix0", pix_log[0][23:0], d0[23:0]);
      chk("dir_stb_latency", acc_cyc[0] - en_cyc, 2);
      chk("dir_line_gap", acc_cyc[4] - acc_cyc[3], 3);
      chk("dir_cyc_drop", acc_low[4] - acc_low[3], 1);
      chk("dir_no_drop_in_line", acc_low[3] - acc_low[0], 0);
    end

    // Random bus timing, consumer stalls and geometry.
    for (int it = 0; it < 8; it++) begin
      base = (it == 0) ? 30'h3FFF_FFF0 : 30'($urandom);
      stride = 12'($urandom_range(0, 64));
      npix = (it == 1) ? 12'd1 : 12'($urandom_range(1, 24));
      nlines = 12'($urandom_range(1, 4));
      stall_pct = $urandom_range(0, 60);
      max_dly = $urandom_range(0, 5);
      ready_mode = 0;
      run_frames($sformatf("rand%0d", it), 2);
    end

    // Consumer blocked: fetch must stop at the credit limit.
    base = 30'h4000;
    npix = 12'd64;
    nlines = 12'd1;
    stride = 12'd64;
    stall_pct = 20;
    max_dly = 5;
    ready_mode = 2;
    vlast_cnt = 0;
    en = 1'b1;
    repeat (200) tick();
    chk("bp_stb_low", stb, 0);
    chk("bp_cyc_held", cyc, 1);
    chk("bp_fill", acked_m - popped_m, 32);
    chk("bp_outstanding", inflight.size(), 0);
    chk("bp_valid", pv, 1);
    ready_mode = 1;
    run_frames("bp", 1);

    // Bus error on the third ack.
    base = 30'h800;
    npix = 12'd8;
    nlines = 12'd2;
    stride = 12'd16;
    stall_pct = 10;
    max_dly = 2;
    ready_mode = 0;
    err_at = 3;
    ack_count = 0;
    err_seen = 0;
    en = 1'b1;
    n = 0;
    while (err_seen == 0 && n < 2000) begin
      tick();
      n++;
    end
    if (err_seen == 0) fail_now("err_timeout");
    chk("err_count", err_seen, 1);
    cyc_hi = 0;
    repeat (40) begin
      tick();
      if (cyc) cyc_hi++;
    end
    chk("err_stay_idle", cyc_hi, 0);
    chk("err_fifo_empty", pv, 0);
    err_at = 0;
    en = 1'b0;
    repeat (2) tick();
    clear_model();
    run_frames("err_recover", 1);

    // Degenerate geometry never starts a bus cycle.
    npix = 12'd0;
    nlines = 12'd3;
    en = 1'b1;
    cyc_hi = 0;
    repeat (40) begin
      tick();
      if (cyc) cyc_hi++;
    end
    chk("zero_npix", cyc_hi, 0);
    npix = 12'd3;
    nlines = 12'd0;
    cyc_hi = 0;
    repeat (40) begin
      tick();
      if (cyc) cyc_hi++;
    end
    chk("zero_nlines", cyc_hi, 0);
    en = 1'b0;
    repeat (2) tick();
    clear_model();

    // Asynchronous reset in the middle of a burst.
    base = 30'h2000;
    npix = 12'd16;
    nlines = 12'd3;
    stride = 12'd32;
    stall_pct = 20;
    max_dly = 3;
    ready_mode = 0;
    addr_log.delete();
    en = 1'b1;
    n = 0;
    while (!(stb && addr_log.size() >= 3) && n < 2000) begin
      tick();
      n++;
    end
    if (!(stb && addr_log.size() >= 3)) fail_now("rst_mid_timeout");
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_cyc", cyc, 0);
    chk("rst_mid_stb", stb, 0);
    chk("rst_mid_valid", pv, 0);
    repeat (2) tick();
    rst = 1'b0;
    clear_model();
    addr_log.delete();
    run_frames("rst_restart", 1);
    if (addr_log.size() == 0)
      fail_now("rst_restart_addr");
    else
      chk("rst_restart_base", addr_log[0], 30'h2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hdmi_frame_reader.md
# hdmi_frame_reader

Wishbone-master frame-buffer reader for the VideoZip video output path. It fetches a rectangular frame from memory, one 32-bit word per pixel in the `{8'h00, R, G, B}` layout the HDMI input capture path writes, and emits it as a pixel stream with valid/ready handshake and end-of-line/end-of-frame markers. It sits between the system bus and the HDMI transmit pipeline, single clock domain; clock crossing to the pixel clock is handled downstream.

## Interface
- `AW`, 30: word-address width.
- `LW`, 12: width of pixel, line and stride counts.
- `LGFIFO`, 5: log2 of pixel FIFO depth (32 entries).

- `i_clk`  in  1  system/bus clock; all logic on rising edge.
- `i_reset`  in  1  reset. One clock; reset is asynchronous and active-high.
- `i_en`  in  1  enable; frames run back-to-back while high.
- `i_base_addr`  in  AW  word address of pixel (0,0).
- `i_words_per_line`  in  LW  line stride in words.
- `i_npix`  in  LW  pixels per line.
- `i_nlines`  in  LW  lines per frame.
- `o_wb_cyc`, `o_wb_stb`  out  1  bus cycle / strobe.
- `o_wb_we`  out  1  constant 0.
- `o_wb_addr`  out  AW  read word address.
- `o_wb_sel`  out  4  constant 4'hf.
- `i_wb_ack`, `i_wb_stall`, `i_wb_err`  in  1  bus responses.
- `i_wb_data`  in  32  read data; bits [23:0] are the pixel.
- `o_pix_valid`  out  1  pixel available.
- `i_pix_ready`  in  1  consumer accepts pixel when valid and ready are both high.
- `o_pix_data`  out  24  {R,G,B}.
- `o_pix_hlast`  out  1  last pixel of line.
- `o_pix_vlast`  out  1  last pixel of frame; only asserted together with hlast.
- `o_err`  out  1  one-cycle pulse on bus error.

## Operation
- States: IDLE, BUS, DRAIN, NEXT.
- IDLE: when `i_en` is high and `i_npix` and `i_nlines` are both nonzero, latch all configuration inputs, set `line_addr` and `o_wb_addr` to base, then go to BUS. Configuration changes during a frame are ignored.
- BUS: `o_wb_cyc` is high. `o_wb_stb` is high while `reqs_left>0` and `fill+outstanding < 2**LGFIFO`; it drops otherwise, with cyc held.
  - A request is accepted on stb && !stall. Each acceptance increments `o_wb_addr` and `outstanding` and decrements `reqs_left`.
  - Go to DRAIN when the last request of the line is accepted.
- DRAIN: stb is low and cyc stays high until `outstanding==0` (including the ack that arrives on that same cycle), then go to NEXT with cyc low.
- NEXT (one cycle): `line_addr += stride` (mod 2^AW), and `o_wb_addr` is set to the new `line_addr`. After the last line: return to BUS if `i_en` is high (relatching configuration), else go to IDLE.
- Each ack writes `{vlast, hlast, i_wb_data[23:0]}` into the FIFO. hlast marks the ack count reaching npix-1 within the line; vlast additionally requires the last line.
- Accept and ack in the same cycle leave `outstanding` unchanged.
- Bus error (`i_wb_err` while cyc):
  - drop cyc/stb next cycle and pulse `o_err`;
  - flush the FIFO and abandon the frame;
  - go to IDLE. A new frame starts only after `i_en` has been low for at least one cycle.
- Dropping `i_en` mid-frame completes the current frame.

## Timing
- Reset values: cyc, stb, we, `o_pix_valid`, hlast, vlast and `o_err` are 0; `o_wb_addr` is 0; `o_wb_sel` is 4'hf; the FIFO is empty and all counters are 0. Asynchronous reset mid-burst drops cyc/stb immediately.
- stb is asserted the cycle after leaving IDLE or NEXT.
- Ack-to-`o_pix_valid` latency is 1 cycle (registered-write, first-word-fall-through FIFO).
- `o_pix_*` are stable while valid && !ready.
- Minimum line overhead is DRAIN plus one NEXT cycle.
- Credit rule: `fill + outstanding <= 2**LGFIFO` at all times, so the FIFO never overflows. An ack beyond the credit limit cannot occur.
- `outstanding` is LGFIFO+1 bits wide; `reqs_left` and the line counters are LW bits wide.

## Structure
- Shared package `hdmi_pkg`:
  - state encoding;
  - pixel word layout constants (PIX_W=24, the HLAST/VLAST bit positions);
  - FIFO entry width 26.
- One sub-module: `sfifo`, a synchronous FIFO with parameters for width and LGFIFO, exposing `o_fill`, a flush input, and first-word-fall-through output.

## Test plan
- Base 0x100, npix 4, nlines 2, stride 8, zero stall, ready=1:
  - addresses 0x100–0x103 then 0x108–0x10B, with cyc dropping between lines;
  - 8 pixels out, hlast on pixels 3 and 7, vlast only on pixel 7.
- Random `i_wb_stall` and ack delays 0–5 cycles: pixel order and data match memory, and `outstanding` never goes negative.
- `i_pix_ready=0` for 200 cycles with npix 64: stb stops once fill+outstanding=32, no FIFO overflow, and streaming resumes when ready rises.
- `i_wb_err` on the 3rd ack: one-cycle `o_err`, cyc low next cycle, FIFO empty, idle until `i_en` toggles.
- npix=0 or nlines=0 with `i_en=1`: cyc never asserts.
- Reset asserted mid-BUS: cyc/stb low asynchronously, and after release a clean frame restarts from base.
